jtframe_pll_phase: RTL and testbench
====================================

# jtframe_pll_phase

Runtime phase-step controller for the SDRAM clock output of the system PLL. It drives the dynamic phase-shift port of the PLL (phase_en/updn/cntsel, answered by phase_done) so firmware or OSD logic can move the SDRAM clock away from its compile-time `SDRAM_SHIFT` position without a rebuild. It sits beside the PLL wrapper, in the PLL reference clock domain, and tracks the current offset in PLL phase steps relative to the compile-time position.

## Interface
- `CNTSEL`, default 5'd1: PLL counter selected for stepping (the shifted 48 MHz output).
- `MAX_STEPS`, default 64: maximum magnitude of the offset, in steps; requested targets are clamped to ±MAX_STEPS.
- `TIMEOUT`, default 1023: clock cycles allowed for each phase_done edge before the step is aborted.
- `SETTLE`, default 15: idle cycles inserted after each completed step.

Ports:
- `clk` in 1: PLL reference clock (50 MHz), single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous; synchronised internally with 2 flops.
- `req` in 1: one-cycle request to move to `target`.
- `target` in 8 (signed): desired offset in steps.
- `busy` out 1: high from request acceptance until `done` or `err`.
- `done` out 1: one-cycle pulse when the position equals the clamped target.
- `err` out 1: one-cycle pulse on timeout or loss of lock.
- `pos` out 8 (signed): current offset in steps.
- `phase_en` out 1: PLL phase-step strobe.
- `updn` out 1: step direction; 1 moves the phase later, 0 moves it earlier.
- `cntsel` out 5: counter select, constant `CNTSEL`.
- `phase_done` in 1: PLL step acknowledge, asynchronous; synchronised internally with 2 flops.

## Operation
- States: IDLE, STROBE, WAIT_LO, WAIT_HI, SETTLE.
- IDLE:
  - A `req` is accepted only when the synchronised lock is high. The controller then latches clamp(target), raises `busy`, and computes the direction.
  - If clamp(target) == `pos`, the controller pulses `done`, clears `busy` on the next cycle and stays in IDLE.
  - Otherwise it sets `updn = (tgt > pos)` and goes to STROBE.
  - A `req` while unlocked pulses `err` and is dropped.
  - A `req` while busy is ignored.
- STROBE: `phase_en` is high for exactly 2 cycles, then the state goes to WAIT_LO.
- WAIT_LO: waits for the synchronised phase_done to be 0, then goes to WAIT_HI.
- WAIT_HI: waits for the synchronised phase_done to be 1. On that edge `pos` increments if `updn` is 1 and decrements otherwise, then the state goes to SETTLE.
- SETTLE: counts `SETTLE` cycles. If `pos` == tgt it pulses `done`, drops `busy` and returns to IDLE; otherwise it goes back to STROBE. `updn` is unchanged between steps.
- Timeout: one counter, reset on entry to WAIT_LO and on entry to WAIT_HI. If it reaches `TIMEOUT` in either state, the controller pulses `err`, drops `busy` and returns to IDLE. `pos` keeps the last completed step.
- Lock loss: falling synchronised lock in any state forces IDLE and sets `pos` to 0, because the PLL returns to its compile-time phase after relock. If the controller was busy it also pulses `err` and drops `busy`. `phase_en` drops on the same cycle.
- Clamp: the 8-bit signed target is saturated to [-MAX_STEPS, +MAX_STEPS] before comparison; -128 with MAX_STEPS = 64 gives -64.
- `pos` never leaves the clamp range and never wraps.

## Timing
- Reset values: `phase_en` 0, `updn` 0, `cntsel` CNTSEL, `busy` 0, `done` 0, `err` 0, `pos` 0, state IDLE.
- Input synchronisers add 2 cycles of latency to `pll_locked` and `phase_done`.
- `busy` rises the cycle after `req`, and `phase_en` rises the same cycle as `busy`.
- Zero-distance request: `done` pulses the cycle after `req`, and `busy` is high for that one cycle only.
- Per step: 2 strobe cycles, plus the PLL response, plus 4 synchroniser cycles (2 edges × 2), plus `SETTLE`.
- `done` and `err` are never high in the same cycle; both are registered.
- Simultaneous lock loss and step completion: lock loss wins, `pos` becomes 0 and `err` pulses.

## Test plan
- Reset, locked, `req` with target=+3, PLL model answers each strobe with phase_done low for 5 cycles -> 3 strobes with `updn`=1, `pos` steps 1, 2, 3, then one `done` pulse; `busy` is low afterwards.
- From `pos`=3, `req` target=-2 -> 5 strobes with `updn`=0, final `pos`=-2, `done` pulses once.
- `req` target=-128 with MAX_STEPS=64 -> stops at `pos`=-64; `req` target=-64 afterwards -> `done` the next cycle with no strobe.
- PLL model never drops phase_done -> `err` after TIMEOUT+1 cycles in WAIT_LO, `pos` unchanged, `busy` low.
- Drop `pll_locked` mid-step at `pos`=2 -> `phase_en` low, `err` pulse, `pos`=0; `req` while unlocked -> `err` pulse and no strobe.
- Assert `rst_n` low mid-step -> all outputs at their reset values immediately, asynchronously.

Source files
------------

// File: rtl/jtframe_pll_phase.sv
// rtl/jtframe_pll_phase.sv - runtime phase-step controller for the PLL SDRAM clock output
module jtframe_pll_phase #(
  parameter logic [4:0] CNTSEL    = 5'd1,
  parameter int         MAX_STEPS = 64,   // 1..127
  parameter int         TIMEOUT   = 1023,
  parameter int         SETTLE    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              req,
  input  logic signed [7:0] target,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic signed [7:0] pos,
  output logic              phase_en,
  output logic              updn,
  output logic [4:0]        cntsel,
  input  logic              phase_done
);

  localparam int CW = $clog2(((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 2);
  localparam logic [CW-1:0]    TO_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0]    ST_C  = CW'(SETTLE);
  localparam logic signed [7:0] MAX_C = 8'(MAX_STEPS);
  localparam logic signed [7:0] MIN_C = -MAX_C;

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT_LO, S_WAIT_HI, S_SETTLE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [7:0]  tgt_q, tgt_d;
  logic signed [7:0]  pos_q, pos_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               phase_en_q, phase_en_d;
  logic               updn_q, updn_d;
  logic               lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d, lock_prev_q, lock_prev_d;
  logic               pd_s1_q, pd_s1_d, pd_s2_q, pd_s2_d;
  logic signed [7:0]  tgt_clamped;
  logic               lock_fall;

  function automatic logic signed [7:0] clamp(input logic signed [7:0] v);
    if (v > MAX_C)      return MAX_C;
    else if (v < MIN_C) return MIN_C;
    else                return v;
  endfunction

  assign tgt_clamped = clamp(target);
  assign lock_fall   = lock_prev_q & ~lock_s2_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign pos      = pos_q;
  assign phase_en = phase_en_q;
  assign updn     = updn_q;
  assign cntsel   = CNTSEL;

  // Next-state logic: step sequencing, timeout abort and lock-loss override
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    pos_d       = pos_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    phase_en_d  = phase_en_q;
    updn_d      = updn_q;
    lock_s1_d   = pll_locked;
    lock_s2_d   = lock_s1_q;
    lock_prev_d = lock_s2_q;
    pd_s1_d     = phase_done;
    pd_s2_d     = pd_s1_q;

    case (state_q)
      S_IDLE: begin
        busy_d     = 1'b0;
        phase_en_d = 1'b0;
        // busy_q here only marks the zero-distance cycle, so requests are ignored
        if (req && !busy_q) begin
          if (!lock_s2_q) begin
            err_d = 1'b1;
          end else begin
            tgt_d  = tgt_clamped;
            busy_d = 1'b1;
            if (tgt_clamped == pos_q) begin
              done_d = 1'b1;
            end else begin
              updn_d     = (tgt_clamped > pos_q);
              phase_en_d = 1'b1;
              cnt_d      = '0;
              state_d    = S_STROBE;
            end
          end
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else begin
          phase_en_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!pd_s2_q) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end else if (cnt_q == TO_C) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HI: begin
        if (pd_s2_q) begin
          pos_d   = updn_q ? pos_q + 8'sd1 : pos_q - 8'sd1;
          cnt_d   = CW'(1);
          state_d = S_SETTLE;
        end else if (cnt_q == TO_C) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q >= ST_C) begin
          if (pos_q == tgt_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            phase_en_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_STROBE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // After relock the PLL is back at its compile-time phase, so the offset is zero
    if (lock_fall) begin
      state_d    = S_IDLE;
      pos_d      = '0;
      phase_en_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_d | busy_q;
      busy_d     = 1'b0;
    end
  end

  // State and output registers, including the two-flop input synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      pos_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      phase_en_q  <= 1'b0;
      updn_q      <= 1'b0;
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      lock_prev_q <= 1'b0;
      pd_s1_q     <= 1'b0;
      pd_s2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      pos_q       <= pos_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      phase_en_q  <= phase_en_d;
      updn_q      <= updn_d;
      lock_s1_q   <= lock_s1_d;
      lock_s2_q   <= lock_s2_d;
      lock_prev_q <= lock_prev_d;
      pd_s1_q     <= pd_s1_d;
      pd_s2_q     <= pd_s2_d;
    end
  end

endmodule

// File: tb/tb_jtframe_pll_phase.sv
// tb/tb_jtframe_pll_phase.sv - directed-vector bench for jtframe_pll_phase
module tb_jtframe_pll_phase;

  logic              clk;
  logic              rst_n;
  logic              pll_locked;
  logic              req;
  logic signed [7:0] target;
  logic              busy;
  logic              done;
  logic              err;
  logic signed [7:0] pos;
  logic              phase_en;
  logic              updn;
  logic [4:0]        cntsel;
  logic              phase_done;

  int vectors;
  int miscompares;

  int strobes;
  int updn_bad;
  int dones;
  int errs;
  int pos_hist[$];
  int pos_prev;
  logic exp_updn;
  logic pll_stuck;
  logic en_prev;
  int lo;

  jtframe_pll_phase dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .req        (req),
    .target     (target),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pos        (pos),
    .phase_en   (phase_en),
    .updn       (updn),
    .cntsel     (cntsel),
    .phase_done (phase_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk);
    strobes  = 0;
    updn_bad = 0;
    dones    = 0;
    errs     = 0;
    pos_hist.delete();
  endtask

  task automatic do_req(input logic signed [7:0] t);
    req    = 1'b1;
    target = t;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(done || err) && n < budget);
    chk(tag, int'(done | err), 1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // PLL phase-shift model plus output monitor
  initial begin
    phase_done = 1'b1;
    en_prev    = 1'b0;
    lo         = 0;
    pos_prev   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (phase_en && !en_prev) begin
        strobes++;
        if (updn !== exp_updn) updn_bad++;
        if (!pll_stuck) lo = 5;
      end
      en_prev = phase_en;
      if (done) dones++;
      if (err) errs++;
      if (int'(pos) != pos_prev) begin
        pos_hist.push_back(int'(pos));
        pos_prev = int'(pos);
      end
      if (lo > 0) begin
        phase_done = 1'b0;
        lo--;
      end else begin
        phase_done = 1'b1;
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    strobes     = 0;
    updn_bad    = 0;
    dones       = 0;
    errs        = 0;
    exp_updn    = 1'b1;
    pll_stuck   = 1'b0;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    req         = 1'b0;
    target      = '0;

    cycles(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pos", int'(pos), 0);
    chk("rst_phase_en", int'(phase_en), 0);
    chk("rst_updn", int'(updn), 0);
    chk("rst_cntsel", int'(cntsel), 1);
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    cycles(5);

    // +3 from 0
    clear_stats();
    exp_updn = 1'b1;
    @(posedge clk); #1;
    do_req(8'sd3);
    chk("p3_busy_rise", int'(busy), 1);
    chk("p3_en_rise", int'(phase_en), 1);
    wait_end(2000, "p3_end");
    cycles(1);
    chk("p3_strobes", strobes, 3);
    chk("p3_updn", updn_bad, 0);
    chk("p3_hist_n", pos_hist.size(), 3);
    if (pos_hist.size() == 3) begin
      chk("p3_hist0", pos_hist[0], 1);
      chk("p3_hist1", pos_hist[1], 2);
      chk("p3_hist2", pos_hist[2], 3);
    end
    chk("p3_dones", dones, 1);
    chk("p3_busy", int'(busy), 0);
    chk("p3_pos", int'(pos), 3);

    // 3 -> -2
    clear_stats();
    exp_updn = 1'b0;
    @(posedge clk); #1;
    do_req(-8'sd2);
    wait_end(3000, "m2_end");
    cycles(1);
    chk("m2_strobes", strobes, 5);
    chk("m2_updn", updn_bad, 0);
    chk("m2_pos", int'(pos), -2);
    chk("m2_dones", dones, 1);
    chk("m2_errs", errs, 0);

    // -128 clamps to -64
    clear_stats();
    exp_updn = 1'b0;
    @(posedge clk); #1;
    do_req(-8'sd128);
    wait_end(20000, "clamp_end");
    cycles(1);
    chk("clamp_pos", int'(pos), -64);
    chk("clamp_strobes", strobes, 62);
    chk("clamp_dones", dones, 1);

    // zero-distance request
    clear_stats();
    @(posedge clk); #1;
    do_req(-8'sd64);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 1);
    chk("zero_en", int'(phase_en), 0);
    cycles(1);
    chk("zero_busy_fall", int'(busy), 0);
    chk("zero_done_fall", int'(done), 0);
    cycles(2);
    chk("zero_strobes", strobes, 0);

    // phase_done never drops -> timeout
    clear_stats();
    pll_stuck = 1'b1;
    exp_updn  = 1'b1;
    @(posedge clk); #1;
    do_req(-8'sd60);
    wait_end(1200, "to_end");
    chk("to_err", int'(err), 1);
    cycles(1);
    chk("to_pos", int'(pos), -64);
    chk("to_busy", int'(busy), 0);
    chk("to_errs", errs, 1);
    chk("to_dones", dones, 0);
    pll_stuck = 1'b0;

    // walk to +2, then lose lock mid-step
    clear_stats();
    exp_updn = 1'b1;
    @(posedge clk); #1;
    do_req(8'sd2);
    wait_end(20000, "walk_end");
    cycles(1);
    chk("walk_pos", int'(pos), 2);
    clear_stats();
    @(posedge clk); #1;
    do_req(8'sd5);
    pll_locked = 1'b0;
    wait_end(20, "ll_end");
    chk("ll_err", int'(err), 1);
    chk("ll_pos", int'(pos), 0);
    chk("ll_en", int'(phase_en), 0);
    chk("ll_busy", int'(busy), 0);
    cycles(1);
    chk("ll_errs", errs, 1);

    // request while unlocked
    clear_stats();
    @(posedge clk); #1;
    do_req(8'sd4);
    cycles(4);
    chk("ul_errs", errs, 1);
    chk("ul_strobes", strobes, 0);
    chk("ul_busy", int'(busy), 0);

    // relock, then asynchronous reset mid-step
    pll_locked = 1'b1;
    cycles(5);
    clear_stats();
    exp_updn = 1'b1;
    @(posedge clk); #1;
    do_req(8'sd5);
    begin
      int n;
      n = 0;
      while (pos != 8'sd2 && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("ar_reach", int'(pos), 2);
    end
    chk("ar_updn_pre", int'(updn), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pos", int'(pos), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_updn", int'(updn), 0);
    chk("ar_en", int'(phase_en), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_err", int'(err), 0);
    chk("ar_cntsel", int'(cntsel), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
